// File: rtl/led_pattern_scheduler_if.sv
// Board-side signal bundle for the LED scheduler: raw switches/buttons in, LED drives out.
interface led_pattern_scheduler_if;
   logic [1:0] sw;
   logic [3:1] btn;
   logic [3:0] led;
   logic       led4_r, led4_g, led4_b;
   logic       led5_r, led5_g, led5_b;

   modport master (
      output sw, btn,
      input  led, led4_r, led4_g, led4_b, led5_r, led5_g, led5_b
   );

   modport slave (
      input  sw, btn,
      output led, led4_r, led4_g, led4_b, led5_r, led5_g, led5_b
   );
endinterface

// File: rtl/led_pattern_scheduler.sv
// User-LED sequencer: debounced buttons drive an IDLE/RUN/PAUSE step machine that
// produces registered green-LED patterns and PWM-dimmed RGB colours.

module lps_debounce #(
   parameter int DB_CYCLES = 250_000
) (
   input  logic clk,
   input  logic rst,
   input  logic sync_i,
   output logic press_o
);
   localparam int CNT_W = $clog2(DB_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             lvl_q, lvl_d;
   logic             press_q, press_d;

   // Count only an unbroken run of disagreeing samples; any agreement restarts it.
   always_comb begin
      cnt_d   = '0;
      lvl_d   = lvl_q;
      press_d = 1'b0;
      if (sync_i != lvl_q) begin
         if (cnt_q == CNT_LAST) begin
            lvl_d   = sync_i;
            press_d = sync_i;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         lvl_q   <= 1'b0;
         press_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         lvl_q   <= lvl_d;
         press_q <= press_d;
      end
   end

   assign press_o = press_q;
endmodule

module led_pattern_scheduler #(
   parameter int STEP_DIV  = 25_000_000,
   parameter int DB_CYCLES = 250_000,
   parameter int PWM_BITS  = 8,
   parameter int DUTY      = 64
) (
   input logic                    clk,
   input logic                    rst,
   led_pattern_scheduler_if.slave io
);
   localparam int STEP_W = $clog2(STEP_DIV);
   localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_DIV - 1);
   localparam logic [PWM_BITS:0]   DUTY_C    = DUTY[PWM_BITS:0];

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE} state_e;

   state_e state_q, state_d;

   logic [1:0]          sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
   logic [3:1]          btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
   logic [3:1]          press;
   logic [3:0]          s_q, s_d;
   logic                dir_q, dir_d;
   logic [STEP_W-1:0]   step_q, step_d;
   logic [PWM_BITS-1:0] pwm_q, pwm_d;
   logic [3:0]          led_q, led_d;
   logic [2:0]          rgb4_q, rgb4_d, rgb5_q, rgb5_d;
   logic                tick, adv, rgb_on;

   function automatic logic [3:0] pattern(input logic [1:0] sel, input logic [3:0] s);
      logic [3:0] one_hot;
      one_hot = 4'b0001 << s[1:0];
      case (sel)
         2'b00:   pattern = one_hot;
         2'b01:   pattern = s;
         2'b10:   pattern = ~one_hot;
         default: pattern = s[0] ? 4'hF : 4'h0;
      endcase
   endfunction

   // {r,g,b}; index 3 lights all channels as white.
   function automatic logic [2:0] colour(input logic [1:0] c);
      case (c)
         2'd0:    colour = 3'b100;
         2'd1:    colour = 3'b010;
         2'd2:    colour = 3'b001;
         default: colour = 3'b111;
      endcase
   endfunction

   always_comb begin
      sw_s1_d  = io.sw;
      sw_s2_d  = sw_s1_q;
      btn_s1_d = io.btn;
      btn_s2_d = btn_s1_q;
   end

   for (genvar i = 1; i <= 3; i++) begin : g_db
      lps_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
         .clk     (clk),
         .rst     (rst),
         .sync_i  (btn_s2_q[i]),
         .press_o (press[i])
      );
   end

   // Next state, step counter and pattern index; btn1 always wins over btn2.
   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      s_d     = s_q;
      dir_d   = dir_q;
      adv     = 1'b0;
      tick    = (state_q == ST_RUN) && (step_q == STEP_LAST);
      case (state_q)
         ST_IDLE: begin
            if (press[1]) begin
               state_d = ST_RUN;
               step_d  = '0;
            end
         end
         ST_RUN: begin
            step_d = tick ? '0 : step_q + STEP_W'(1);
            adv    = tick;
            if (press[1]) state_d = ST_PAUSE;
         end
         ST_PAUSE: begin
            if (press[1]) state_d = ST_RUN;
            else          adv     = press[2];
         end
         default: state_d = ST_IDLE;
      endcase
      if (adv) s_d = dir_q ? s_q - 4'd1 : s_q + 4'd1;
      if (press[3] && (state_q != ST_IDLE)) dir_d = ~dir_q;
   end

   always_comb begin
      pwm_d  = pwm_q + PWM_BITS'(1);
      rgb_on = (state_q == ST_RUN) && ({1'b0, pwm_q} < DUTY_C);
      led_d  = (state_q == ST_IDLE) ? 4'h0 : pattern(sw_s2_q, s_q);
      rgb4_d = rgb_on ? colour(s_q[1:0]) : 3'b000;
      rgb5_d = rgb_on ? colour(s_q[1:0] + 2'd2) : 3'b000;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         sw_s1_q  <= '0;
         sw_s2_q  <= '0;
         btn_s1_q <= '0;
         btn_s2_q <= '0;
         s_q      <= '0;
         dir_q    <= 1'b0;
         step_q   <= '0;
         pwm_q    <= '0;
         led_q    <= '0;
         rgb4_q   <= '0;
         rgb5_q   <= '0;
      end else begin
         state_q  <= state_d;
         sw_s1_q  <= sw_s1_d;
         sw_s2_q  <= sw_s2_d;
         btn_s1_q <= btn_s1_d;
         btn_s2_q <= btn_s2_d;
         s_q      <= s_d;
         dir_q    <= dir_d;
         step_q   <= step_d;
         pwm_q    <= pwm_d;
         led_q    <= led_d;
         rgb4_q   <= rgb4_d;
         rgb5_q   <= rgb5_d;
      end
   end

   assign io.led    = led_q;
   assign io.led4_r = rgb4_q[2];
   assign io.led4_g = rgb4_q[1];
   assign io.led4_b = rgb4_q[0];
   assign io.led5_r = rgb5_q[2];
   assign io.led5_g = rgb5_q[1];
   assign io.led5_b = rgb5_q[0];
endmodule

// File: tb/tb_led_pattern_scheduler.sv
// Randomized and directed bench for led_pattern_scheduler against a cycle-level reference model.
module tb_led_pattern_scheduler;
   localparam int SD = 4;
   localparam int DB = 3;
   localparam int PB = 3;
   localparam int DU = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   led_pattern_scheduler_if bus();

   led_pattern_scheduler #(.STEP_DIV(SD), .DB_CYCLES(DB), .PWM_BITS(PB), .DUTY(DU)) dut (
      .clk (clk),
      .rst (rst),
      .io  (bus)
   );

   always #5 clk = ~clk;

   wire [9:0] outs = {bus.led, bus.led4_r, bus.led4_g, bus.led4_b,
                      bus.led5_r, bus.led5_g, bus.led5_b};

   // Reference model: mode 0 idle, 1 run, 2 pause.
   logic [9:0] exp_outs = '0;
   int         m_mode = 0, m_s = 0, m_dir = 0, m_run = 0, m_pwm = 0;
   logic [3:1] bh0 = '0, bh1 = '0;
   logic [1:0] swh0 = '0, swh1 = '0;
   logic [3:1] m_db = '0, m_press = '0;
   logic [3:1] win [0:DB-1];

   function automatic logic [3:0] ref_led(int mode, int s, logic [1:0] sw);
      if (mode == 0) return 4'h0;
      case (sw)
         2'd0:    return 4'(1 << (s % 4));
         2'd1:    return 4'(s);
         2'd2:    return ~4'(1 << (s % 4));
         default: return (s % 2 == 1) ? 4'hF : 4'h0;
      endcase
   endfunction

   function automatic logic [2:0] ref_col(int c);
      case (c)
         0:       return 3'b100;
         1:       return 3'b010;
         2:       return 3'b001;
         default: return 3'b111;
      endcase
   endfunction

   always @(posedge clk) begin : model
      logic [3:1] p;
      logic       on, tick, adv, all_diff;
      int         mode0;
      if (rst) begin
         exp_outs = '0;
         m_mode = 0; m_s = 0; m_dir = 0; m_run = 0; m_pwm = 0;
         bh0 = '0; bh1 = '0; swh0 = '0; swh1 = '0;
         m_db = '0; m_press = '0;
         for (int k = 0; k < DB; k++) win[k] = '0;
      end else begin
         on = (m_mode == 1) && (m_pwm < DU);
         exp_outs = {ref_led(m_mode, m_s, swh1),
                     on ? ref_col(m_s % 4) : 3'b000,
                     on ? ref_col((m_s + 2) % 4) : 3'b000};
         p     = m_press;
         mode0 = m_mode;
         tick  = (m_mode == 1) && (m_run % SD == SD - 1);
         adv   = 1'b0;
         case (mode0)
            0: if (p[1]) begin m_mode = 1; m_run = 0; end
            1: begin adv = tick; m_run++; if (p[1]) m_mode = 2; end
            default: if (p[1]) m_mode = 1; else adv = p[2];
         endcase
         if (adv) m_s = (m_dir != 0) ? (m_s + 15) % 16 : (m_s + 1) % 16;
         if (mode0 != 0 && p[3]) m_dir = 1 - m_dir;
         m_pwm = (m_pwm + 1) % (1 << PB);
         for (int k = DB - 1; k > 0; k--) win[k] = win[k-1];
         win[0]  = bh1;
         m_press = '0;
         for (int b = 1; b <= 3; b++) begin
            all_diff = 1'b1;
            for (int k = 0; k < DB; k++) if (win[k][b] == m_db[b]) all_diff = 1'b0;
            if (all_diff) begin
               m_db[b]    = ~m_db[b];
               m_press[b] = m_db[b];
            end
         end
         bh1 = bh0; bh0 = bus.btn;
         swh1 = swh0; swh0 = bus.sw;
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse(input logic [3:1] b, input int hi, input int lo);
      bus.btn = b;
      repeat (hi) @(negedge clk);
      bus.btn = '0;
      repeat (lo) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; bus.btn = '0; bus.sw = 2'b00;
      idle(2);
      total++;
      if (outs !== 10'h0) begin bad++; $display("FAIL reset_outs got=%h exp=%h", outs, 10'h0); end
      rst = 1'b0;
      idle(3);
      total++;
      if (outs !== 10'h0) begin bad++; $display("FAIL idle_outs got=%h exp=%h", outs, 10'h0); end
   endtask

   task automatic test_start_walk();
      logic [3:0] e;
      logic       chk;
      bus.sw = 2'b00;
      for (int c = 1; c <= 24; c++) begin
         bus.btn = (c <= 10) ? 3'b001 : 3'b000;
         @(negedge clk);
         total++;
         if (outs !== exp_outs) begin bad++; $display("FAIL start_model c=%0d got=%h exp=%h", c, outs, exp_outs); end
         chk = 1'b1;
         case (c)
            6:       e = 4'b0000;
            7:       e = 4'b0001;
            11:      e = 4'b0010;
            15:      e = 4'b0100;
            19:      e = 4'b1000;
            23:      e = 4'b0001;
            default: begin e = 4'b0000; chk = 1'b0; end
         endcase
         if (chk) begin
            total++;
            if (bus.led !== e) begin bad++; $display("FAIL start_walk c=%0d got=%b exp=%b", c, bus.led, e); end
         end
      end
   endtask

   task automatic test_pause_step();
      int sb;
      bus.sw = 2'b01;
      pulse(3'b001, 10, 10);
      total++;
      if (outs[5:0] !== 6'h0) begin bad++; $display("FAIL pause_rgb got=%h exp=0", outs[5:0]); end
      total++;
      if (outs !== exp_outs) begin bad++; $display("FAIL pause_model got=%h exp=%h", outs, exp_outs); end
      for (int i = 0; i < 3; i++) begin
         sb = m_s;
         pulse(3'b010, 10, 6);
         total++;
         if (bus.led !== 4'((sb + 1) % 16)) begin
            bad++; $display("FAIL pause_step%0d got=%h exp=%h", i, bus.led, 4'((sb + 1) % 16));
         end
      end
      pulse(3'b001, 10, 0);
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         total++;
         if (outs !== exp_outs) begin bad++; $display("FAIL resume_model c=%0d got=%h exp=%h", c, outs, exp_outs); end
      end
   endtask

   task automatic test_reverse_wrap();
      pulse(3'b001, 10, 10);
      bus.sw = 2'b01;
      for (int i = 0; i < 16 && m_s != 0; i++) pulse(3'b010, 10, 6);
      total++;
      if (bus.led !== 4'h0) begin bad++; $display("FAIL wrap_s0 got=%h exp=0", bus.led); end
      pulse(3'b100, 10, 6);
      pulse(3'b010, 10, 6);
      total++;
      if (bus.led !== 4'hF) begin bad++; $display("FAIL wrap_rev got=%h exp=f", bus.led); end
      pulse(3'b010, 2, 10);
      total++;
      if (bus.led !== 4'hF) begin bad++; $display("FAIL glitch got=%h exp=f", bus.led); end
      total++;
      if (outs !== exp_outs) begin bad++; $display("FAIL wrap_model got=%h exp=%h", outs, exp_outs); end
   endtask

   task automatic test_simultaneous();
      int sb;
      bus.sw = 2'b01;
      pulse(3'b001, 10, 10);
      pulse(3'b011, 10, 10);
      total++;
      if (outs[5:0] !== 6'h0) begin bad++; $display("FAIL simul_rgb got=%h exp=0", outs[5:0]); end
      total++;
      if (outs !== exp_outs) begin bad++; $display("FAIL simul_model got=%h exp=%h", outs, exp_outs); end
      sb = m_s;
      idle(12);
      total++;
      if (bus.led !== 4'(sb)) begin bad++; $display("FAIL simul_hold got=%h exp=%h", bus.led, 4'(sb)); end
   endtask

   task automatic test_reset_midrun();
      bit found = 1'b0;
      bus.sw = 2'b01;
      pulse(3'b001, 10, 0);
      for (int c = 0; c < 200 && !found; c++) begin
         @(negedge clk);
         if (m_s == 9 && m_mode == 1) found = 1'b1;
      end
      total++;
      if (!found) begin bad++; $display("FAIL reach_s9 got=timeout exp=s9"); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++;
      if (outs !== 10'h0) begin bad++; $display("FAIL midrun_rst got=%h exp=0", outs); end
      pulse(3'b010, 10, 6);
      total++;
      if (outs !== 10'h0) begin bad++; $display("FAIL idle_btn2 got=%h exp=0", outs); end
      bus.sw = 2'b00;
      pulse(3'b001, 7, 0);
      total++;
      if (bus.led !== 4'b0001) begin bad++; $display("FAIL restart_s0 got=%b exp=0001", bus.led); end
      idle(4);
   endtask

   task automatic test_random();
      int hold [1:3];
      for (int b = 1; b <= 3; b++) hold[b] = 0;
      for (int c = 0; c < 4000; c++) begin
         for (int b = 1; b <= 3; b++) begin
            if (hold[b] == 0) begin
               bus.btn[b] = 1'($urandom_range(0, 1));
               hold[b]    = $urandom_range(1, 14);
            end else begin
               hold[b]--;
            end
         end
         if ($urandom_range(0, 39) == 0) bus.sw = 2'($urandom_range(0, 3));
         rst = ($urandom_range(0, 699) == 0);
         @(negedge clk);
         total++;
         if (outs !== exp_outs) begin bad++; $display("FAIL random_model c=%0d got=%h exp=%h", c, outs, exp_outs); end
      end
      rst = 1'b0;
      bus.btn = '0;
   endtask

   initial begin
      bus.btn = '0;
      bus.sw  = 2'b00;
      @(negedge clk);
      test_reset();
      test_start_walk();
      test_pause_step();
      test_reverse_wrap();
      test_simultaneous();
      test_reset_midrun();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
